wb_pipe_stage: RTL and testbench

Parametrised MEM→WB pipeline stage register, successor of the fixed-width memWb latch. It carries the write-back control field, memory read data, ALU result and destination register index from the memory stage to the write-back stage. Unlike the plain latch, it has a valid/ready handshake with a 2-entry skid buffer for back-pressure, a synchronous flush, and a forwarding port. A saturating stall counter is provided for performance debug.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/skid_reg.sv | 106 ++++++++++
 rtl/wb_pipe_stage.sv | 108 ++++++++++
 tb/tb_wb_pipe_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg
// Shared definitions for the MEM->WB pipeline stage and its skid buffer.
// Contents:
//   - default field widths for the stage parameters
//   - bit positions of the write-back control flags inside the ctrl field
//   - occupancy state enum of the 2-entry skid buffer
//   - helper that computes the packed payload width carried by the buffer
package wb_pkg;

  // Default widths of the stage parameters.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  // regWrite always sits in the top bit of the ctrl field. This constant
  // gives its position for the default width; wider ctrl fields use CTRL_W-1.
  localparam int WB_REGWRITE_BIT = CTRL_W_DEF - 1;
  localparam int WB_MEMTOREG_BIT = 0;

  // Occupancy of the skid buffer: nothing held, head only, head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Width of the packed beat {ctrl, rdata, alu, dest}.
  function automatic int wbPayloadWidth(input int ctrlW, input int dataW, input int addrW);
    return ctrlW + 2 * dataW + addrW;
  endfunction

endpackage

// File: rtl/skid_reg.sv
// skid_reg
// Generic 2-entry valid/ready skid buffer on a packed payload.
// The head register drives the output; the skid register catches the one
// beat that can arrive while the head is blocked. The upstream ready is a
// registered flag (skid register not occupied), so there is never a
// combinational path from i_ready to o_ready.
// Ports:
//   clock, reset  single clock, asynchronous active-high reset
//   i_flush       drop every held beat at the next edge
//   i_valid       upstream beat present
//   o_ready       buffer can take a beat (registered)
//   i_data        upstream payload
//   o_valid       head beat present
//   i_ready       downstream consumes the head beat
//   o_data        head payload
module skid_reg
  import wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_e  r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_inReady;
  logic         r_outValid;

  logic         w_accept;
  logic         w_pop;

  // Handshakes are judged against the registered flags only, so a beat is
  // accepted exactly when the upstream sees ready high.
  assign w_accept = i_valid & r_inReady;
  assign w_pop    = r_outValid & i_ready;

  // Occupancy state machine. The ready and valid flags are registered
  // alongside the state so they always agree with it: ready is low only in
  // FULL, valid is high in ONE and FULL. Flush outranks every transfer and
  // also throws away any beat being accepted in the same cycle; the data
  // registers keep stale contents since nothing reads them while invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_head     <= '0;
      r_skid     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else if (i_flush) begin
      r_state    <= ST_EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_head     <= i_data;
            r_outValid <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            // Streaming: the new beat replaces the one leaving.
            r_head <= i_data;
          end else if (w_pop) begin
            r_outValid <= 1'b0;
            r_state    <= ST_EMPTY;
          end else if (w_accept) begin
            // Head is blocked, park the new beat and close the input.
            r_skid    <= i_data;
            r_inReady <= 1'b0;
            r_state   <= ST_FULL;
          end
        end
        ST_FULL: begin
          // Input is closed here, so only a pop can move things along.
          if (w_pop) begin
            r_head    <= r_skid;
            r_inReady <= 1'b1;
            r_state   <= ST_ONE;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_inReady;
  assign o_valid = r_outValid;
  assign o_data  = r_head;

endmodule

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage
// MEM->WB pipeline stage register with valid/ready handshake, 2-entry skid
// buffer for back-pressure, synchronous flush, a forwarding port driven from
// the head beat, and a saturating stall counter for performance debug.
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   flush               drop all held beats at the next edge
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_ctrl             WB control: top bit regWrite, bit 0 memToReg
//   in_rdata, in_alu    memory read data and ALU result
//   in_dest             destination register index
//   out_valid/out_ready downstream handshake for the head beat
//   out_ctrl/rdata/alu/dest  head beat fields, bit-exact copies of the input
//   out_reg_write       head valid and regWrite set
//   out_mem_to_reg      memToReg bit of the head beat
//   fwd_valid/dest/value forwarding view of the head beat
//   stall_count         saturating count of cycles with head valid but blocked
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [ADDR_W-1:0] in_dest,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_alu,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,

  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value,

  output logic [CNT_W-1:0]  stall_count
);

  localparam int PAYLOAD_W   = wbPayloadWidth(CTRL_W, DATA_W, ADDR_W);
  localparam int REGWRITE_BIT = CTRL_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAYLOAD_W-1:0] w_inPayload;
  logic [PAYLOAD_W-1:0] w_outPayload;
  logic                 w_stalled;
  logic [CNT_W-1:0]     r_stallCount;

  // Pack the beat with ctrl in the top bits and dest in the bottom bits.
  assign w_inPayload = {in_ctrl, in_rdata, in_alu, in_dest};

  skid_reg #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_inPayload),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_outPayload)
  );

  assign {out_ctrl, out_rdata, out_alu, out_dest} = w_outPayload;

  // regWrite is qualified with valid so that stale head data left behind by
  // a flush or pop can never trigger a register-file write or a forward.
  // memToReg is a plain mux select and needs no qualification.
  assign out_reg_write  = out_valid & out_ctrl[REGWRITE_BIT];
  assign out_mem_to_reg = out_ctrl[WB_MEMTOREG_BIT];

  // Forwarding looks only at the head beat; the skid beat is younger and
  // must not be forwarded ahead of it.
  assign fwd_valid = out_reg_write;
  assign fwd_dest  = out_dest;
  assign fwd_value = out_mem_to_reg ? out_rdata : out_alu;

  assign w_stalled = out_valid & ~out_ready;

  // Stall counter: counts cycles where the head is held by the write-back
  // stage and sticks at all-ones. Only reset clears it, so a flush does not
  // lose the debug history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stallCount <= '0;
    end else if (w_stalled && (r_stallCount != CNT_MAX)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb_wb_pipe_stage
// Directed and randomized stimulus for wb_pipe_stage, compared against a
// queue-based reference model of the stage (at most two beats in flight,
// head of the queue is the visible beat) and a saturating stall count.
module tb_wb_pipe_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;
  localparam int NW = 3;
  localparam int STALL_MAX = (1 << NW) - 1;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_rdata;
  logic [DW-1:0] in_alu;
  logic [AW-1:0] in_dest;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_rdata;
  logic [DW-1:0] out_alu;
  logic [AW-1:0] out_dest;
  logic          out_reg_write;
  logic          out_mem_to_reg;
  logic          fwd_valid;
  logic [AW-1:0] fwd_dest;
  logic [DW-1:0] fwd_value;
  logic [NW-1:0] stall_count;

  wb_pipe_stage #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ctrl        (in_ctrl),
    .in_rdata       (in_rdata),
    .in_alu         (in_alu),
    .in_dest        (in_dest),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ctrl       (out_ctrl),
    .out_rdata      (out_rdata),
    .out_alu        (out_alu),
    .out_dest       (out_dest),
    .out_reg_write  (out_reg_write),
    .out_mem_to_reg (out_mem_to_reg),
    .fwd_valid      (fwd_valid),
    .fwd_dest       (fwd_dest),
    .fwd_value      (fwd_value),
    .stall_count    (stall_count)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rdata;
    logic [DW-1:0] alu;
    logic [AW-1:0] dest;
  } beat_t;

  beat_t mQ[$];
  int    mStall;
  int    checks;
  int    errors;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the stage.
  task automatic checkOutput();
    beat_t h;
    check("out_valid", 64'(out_valid), 64'(mQ.size() > 0));
    check("in_ready", 64'(in_ready), 64'(mQ.size() < 2));
    check("stall_count", 64'(stall_count), 64'(mStall));
    if (mQ.size() > 0) begin
      h = mQ[0];
      check("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
      check("out_rdata", 64'(out_rdata), 64'(h.rdata));
      check("out_alu", 64'(out_alu), 64'(h.alu));
      check("out_dest", 64'(out_dest), 64'(h.dest));
      check("out_reg_write", 64'(out_reg_write), 64'(h.ctrl[CW-1]));
      check("out_mem_to_reg", 64'(out_mem_to_reg), 64'(h.ctrl[0]));
      check("fwd_valid", 64'(fwd_valid), 64'(h.ctrl[CW-1]));
      check("fwd_dest", 64'(fwd_dest), 64'(h.dest));
      check("fwd_value", 64'(fwd_value), 64'(h.ctrl[0] ? h.rdata : h.alu));
    end else begin
      check("idle_reg_write", 64'(out_reg_write), 64'd0);
      check("idle_fwd_valid", 64'(fwd_valid), 64'd0);
    end
  endtask

  // Drive one cycle of inputs, check outputs, advance the model over the edge.
  task automatic applyStimulus(input logic v, input logic [CW-1:0] c,
                               input logic [DW-1:0] rd, input logic [DW-1:0] al,
                               input logic [AW-1:0] d, input logic ordy, input logic fl);
    bit    acc;
    bit    pop;
    beat_t b;
    in_valid  = v;
    in_ctrl   = c;
    in_rdata  = rd;
    in_alu    = al;
    in_dest   = d;
    out_ready = ordy;
    flush     = fl;
    checkOutput();
    acc = v && (mQ.size() < 2);
    pop = (mQ.size() > 0) && ordy;
    if ((mQ.size() > 0) && !ordy && (mStall < STALL_MAX)) mStall++;
    b.ctrl  = c;
    b.rdata = rd;
    b.alu   = al;
    b.dest  = d;
    @(posedge clock);
    if (fl) begin
      mQ.delete();
    end else begin
      if (pop) void'(mQ.pop_front());
      if (acc) mQ.push_back(b);
    end
    #1;
  endtask

  // Safety net in case the DUT or bench wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    mStall    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_rdata  = '0;
    in_alu    = '0;
    in_dest   = '0;
    out_ready = 1'b0;

    // Reset values.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_out_rdata", 64'(out_rdata), 64'd0);
    check("rst_out_alu", 64'(out_alu), 64'd0);
    check("rst_out_dest", 64'(out_dest), 64'd0);
    check("rst_reg_write", 64'(out_reg_write), 64'd0);
    check("rst_mem_to_reg", 64'(out_mem_to_reg), 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_fwd_dest", 64'(fwd_dest), 64'd0);
    check("rst_fwd_value", 64'(fwd_value), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Streaming: one beat per cycle, each visible one cycle later.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'b10, DW'($urandom), DW'(i), AW'(i), 1'b1, 1'b0);
      check("stream_fwd_value", 64'(fwd_value), 64'(i));
    end
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);

    // Back-pressure: A then B held, then both delivered in order.
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h11, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h22, 5'd2, 1'b0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_head_a", 64'(out_alu), 64'h11);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
    check("bp_head_b", 64'(out_alu), 64'h22);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);

    // memToReg selection and regWrite gating of the forward.
    applyStimulus(1'b1, 2'b11, 32'hDEAD, 32'hBEEF, 5'd3, 1'b1, 1'b0);
    check("m2r_fwd_rdata", 64'(fwd_value), 64'hDEAD);
    applyStimulus(1'b1, 2'b10, 32'hDEAD, 32'hBEEF, 5'd4, 1'b1, 1'b0);
    check("m2r_fwd_alu", 64'(fwd_value), 64'hBEEF);
    applyStimulus(1'b1, 2'b00, 32'hDEAD, 32'hBEEF, 5'd5, 1'b1, 1'b0);
    check("m2r_no_write", 64'(fwd_valid), 64'd0);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);

    // Flush while full with a beat offered: everything dropped.
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h33, 5'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h44, 5'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h55, 5'd8, 1'b0, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);

    // Reset mid-stream: takes effect before the next edge.
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h66, 5'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h77, 5'd10, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_stall", 64'(stall_count), 64'd0);
    mQ.delete();
    mStall = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Stall counter saturation, and flush leaves it untouched.
    applyStimulus(1'b1, 2'b10, DW'($urandom), 32'h88, 5'd11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    check("sat_stall", 64'(stall_count), 64'(STALL_MAX));
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
    check("sat_after_flush", 64'(stall_count), 64'(STALL_MAX));

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, CW'($urandom), DW'($urandom), DW'($urandom),
                    AW'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
